// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int OVERSAMPLE      = 16;
    localparam int TICK_CNT_W      = 5;

    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;
    localparam int DEFAULT_DVSR    = 163;

endpackage

// File: rtl/baud_gen.sv
// Oversample tick generator: one-cycle s_tick every DVSR clocks, held in phase by clr.
module baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR = DEFAULT_DVSR
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic s_tick
);

    localparam int                 CNT_W    = $clog2(DVSR);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DVSR - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign s_tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO: start bit,
// DBIT data bits LSB-first, then a stop bit of SB_TICK oversample ticks.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK,
    parameter int DVSR    = DEFAULT_DVSR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int BIT_CNT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TICK_CNT_W-1:0] OS_LAST   = TICK_CNT_W'(OVERSAMPLE - 1);
    localparam logic [TICK_CNT_W-1:0] STOP_LAST = TICK_CNT_W'(SB_TICK - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DBIT - 1);

    tx_state_t              state_reg;
    logic [TICK_CNT_W-1:0]  tick_reg;
    logic [BIT_CNT_W-1:0]   bit_reg;
    logic [DBIT-1:0]        shift_reg;
    logic [DBIT-1:0]        shift_next;
    logic                   tx_reg;
    logic                   busy_reg;
    logic                   s_tick;
    logic                   baud_clr;

    // Holding the divider at zero in IDLE makes every bit period start phase-aligned.
    assign baud_clr = (state_reg == IDLE);

    baud_gen #(
        .DVSR (DVSR)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .clr    (baud_clr),
        .s_tick (s_tick)
    );

    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_reg <= START;
                        shift_reg <= fifo_r_data;
                        tick_reg  <= '0;
                        bit_reg   <= '0;
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tick_reg == OS_LAST) begin
                            state_reg <= DATA;
                            tick_reg  <= '0;
                            bit_reg   <= '0;
                            tx_reg    <= shift_reg[0];
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick_reg == OS_LAST) begin
                            tick_reg  <= '0;
                            shift_reg <= shift_next;
                            if (bit_reg == BIT_LAST) begin
                                state_reg <= STOP;
                                tx_reg    <= 1'b1;
                            end else begin
                                bit_reg <= bit_reg + 1'b1;
                                tx_reg  <= shift_next[0];
                            end
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (tick_reg == STOP_LAST) begin
                            state_reg <= IDLE;
                            tick_reg  <= '0;
                            busy_reg  <= 1'b0;
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Pop is suppressed during reset so a word is never dropped by a pop the FSM ignores.
    assign fifo_rd      = (state_reg == IDLE) && !fifo_empty && !reset;
    assign tx_done_tick = (state_reg == STOP) && s_tick && (tick_reg == STOP_LAST);
    assign tx           = tx_reg;
    assign tx_busy      = busy_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (1 and 1.5 stop bits) fed from queue FIFOs,
// compared every cycle against a frame-timing model.
module tb_fifo_uart_tx;

    localparam int DVSR = 2;
    localparam int DBIT = 8;
    localparam int BITC = 16 * DVSR;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       empty_a = 1'b1, empty_b = 1'b1;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic       rd_a, tx_a, busy_a, done_a;
    logic       rd_b, tx_b, busy_b, done_b;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(16), .DVSR(DVSR)) dut_a (
        .clk(clk), .reset(reset), .fifo_empty(empty_a), .fifo_r_data(data_a),
        .fifo_rd(rd_a), .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a)
    );

    fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(24), .DVSR(DVSR)) dut_b (
        .clk(clk), .reset(reset), .fifo_empty(empty_b), .fifo_r_data(data_b),
        .fifo_rd(rd_b), .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b)
    );

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state per instance: frame in flight, first cycle of start bit, byte.
    bit         inf[2];
    int         fstart[2];
    logic [7:0] fbyte[2];
    int         tpop[2];
    int         rd_cnt[2];
    int         done_cnt[2];
    int         sb[2] = '{16, 24};

    function automatic int flen(input int i);
        return (16 * (DBIT + 1) + sb[i]) * DVSR;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        empty_a = (qa.size() == 0);
        data_a  = (qa.size() != 0) ? qa[0] : 8'h00;
        empty_b = (qb.size() == 0);
        data_b  = (qb.size() != 0) ? qb[0] : 8'h00;
    endtask

    task automatic check_one(input int i, input string nm, input logic rd, input logic txv,
                             input logic busy, input logic done, input bit nonempty);
        logic etx, ebusy, edone, erd;
        int   o, bi;
        if (inf[i]) begin
            o  = cyc - fstart[i];
            bi = o / BITC;
            if (bi == 0)         etx = 1'b0;
            else if (bi <= DBIT) etx = fbyte[i][bi-1];
            else                 etx = 1'b1;
            ebusy = 1'b1;
            edone = (o == flen(i) - 1);
            erd   = 1'b0;
        end else begin
            etx   = 1'b1;
            ebusy = 1'b0;
            edone = 1'b0;
            erd   = nonempty && !reset;
        end
        chk({"tx_", nm}, {31'd0, txv}, {31'd0, etx});
        chk({"busy_", nm}, {31'd0, busy}, {31'd0, ebusy});
        chk({"done_", nm}, {31'd0, done}, {31'd0, edone});
        chk({"rd_", nm}, {31'd0, rd}, {31'd0, erd});
        if (rd) begin
            rd_cnt[i]++;
            tpop[i] = cyc;
        end
        if (done) begin
            done_cnt[i]++;
            chk({"frame_len_", nm}, cyc - tpop[i], flen(i));
        end
    endtask

    task automatic advance(input int i, input bit nonempty, input logic [7:0] head);
        if (reset) begin
            inf[i] = 1'b0;
        end else if (inf[i]) begin
            if (cyc - fstart[i] == flen(i) - 1) inf[i] = 1'b0;
        end else if (nonempty) begin
            inf[i]    = 1'b1;
            fstart[i] = cyc + 1;
            fbyte[i]  = head;
        end
    endtask

    task automatic step();
        logic ra, rb;
        @(negedge clk);
        check_one(0, "a", rd_a, tx_a, busy_a, done_a, qa.size() != 0);
        check_one(1, "b", rd_b, tx_b, busy_b, done_b, qb.size() != 0);
        advance(0, qa.size() != 0, data_a);
        advance(1, qb.size() != 0, data_b);
        ra = rd_a;
        rb = rd_b;
        @(posedge clk);
        #1;
        cyc++;
        if (ra && qa.size() != 0) void'(qa.pop_front());
        if (rb && qb.size() != 0) void'(qb.pop_front());
        drive_fifo();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((inf[0] || inf[1] || qa.size() != 0 || qb.size() != 0) && n < budget);
        chk("idle_timeout", {31'd0, (n < budget)}, 32'd1);
        step();
    endtask

    task automatic clear_counts();
        rd_cnt   = '{0, 0};
        done_cnt = '{0, 0};
    endtask

    initial begin
        int n;
        inf = '{1'b0, 1'b0};
        clear_counts();

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_tx_a",   {31'd0, tx_a},   32'd1);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_rd_a",   {31'd0, rd_a},   32'd0);
        chk("rst_done_a", {31'd0, done_a}, 32'd0);
        chk("rst_tx_b",   {31'd0, tx_b},   32'd1);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        reset = 1'b0;

        // Idle hold
        repeat (1000) step();
        chk("idle_rd_cnt",   rd_cnt[0] + rd_cnt[1], 0);
        chk("idle_done_cnt", done_cnt[0] + done_cnt[1], 0);

        // Single word 0xA5, one stop bit
        clear_counts();
        qa.push_back(8'hA5);
        drive_fifo();
        run_until_idle(1000);
        chk("single_rd_cnt",   rd_cnt[0], 1);
        chk("single_done_cnt", done_cnt[0], 1);
        chk("single_empty",    {31'd0, empty_a}, 32'd1);

        // Back-to-back preloaded words
        clear_counts();
        qa.push_back(8'h00);
        qa.push_back(8'hFF);
        qa.push_back(8'h3C);
        drive_fifo();
        run_until_idle(2000);
        chk("b2b_rd_cnt",   rd_cnt[0], 3);
        chk("b2b_done_cnt", done_cnt[0], 3);

        // 1.5 stop bits
        clear_counts();
        qb.push_back(8'h81);
        drive_fifo();
        run_until_idle(1000);
        chk("sb24_rd_cnt",   rd_cnt[1], 1);
        chk("sb24_done_cnt", done_cnt[1], 1);

        // Random bytes on both instances at once
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            qa.push_back(8'($urandom_range(0, 255)));
            qb.push_back(8'($urandom_range(0, 255)));
        end
        drive_fifo();
        run_until_idle(3000);
        chk("rand_rd_a",   rd_cnt[0], 4);
        chk("rand_done_a", done_cnt[0], 4);
        chk("rand_rd_b",   rd_cnt[1], 4);
        chk("rand_done_b", done_cnt[1], 4);

        // Reset during data bit 4 of 0x55
        qa.push_back(8'h55);
        drive_fifo();
        n = 0;
        while (!(inf[0] && (cyc - fstart[0] == 5 * BITC + 10)) && n < 1000) begin
            step();
            n++;
        end
        chk("rst_reach_timeout", {31'd0, (n < 1000)}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_tx",   {31'd0, tx_a},   32'd1);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        clear_counts();
        repeat (400) step();
        chk("midrst_rd_cnt",   rd_cnt[0], 0);
        chk("midrst_done_cnt", done_cnt[0], 0);

        // FIFO content changes while a frame is in flight
        clear_counts();
        qa.push_back(8'h96);
        drive_fifo();
        repeat (100) step();
        qa.push_back(8'h11);
        drive_fifo();
        repeat (50) step();
        qa.delete();
        drive_fifo();
        run_until_idle(1000);
        chk("midempty_rd_cnt",   rd_cnt[0], 1);
        chk("midempty_done_cnt", done_cnt[0], 1);
        qa.push_back(8'h11);
        drive_fifo();
        run_until_idle(1000);
        chk("refill_rd_cnt",   rd_cnt[0], 2);
        chk("refill_done_cnt", done_cnt[0], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
